// File: rtl/sdr_wb_bist_master.sv
// Wishbone classic-cycle BIST master for the SDRAM controller slave port.
// It writes a per-word pattern to NUM_WORDS consecutive words and then reads
// them back and compares. It reports pass/fail, a saturating mismatch count,
// the first failing address and an ack-timeout flag.
module sdr_wb_bist_master #(
    parameter int AW        = 26,
    parameter int NUM_WORDS = 16,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start,
    input  logic          sdram_init_done,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [31:0]   wb_dat_o,
    input  logic [31:0]   wb_dat_i,
    input  logic          wb_ack_i,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_count,
    output logic [AW-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_GAP, S_DONE
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
    localparam logic [15:0] TMO_MAX  = 16'(TIMEOUT - 1);

    state_t        state, nxt;
    logic [15:0]   idx;
    logic [15:0]   tcnt;
    logic [47:0]   addr_sum;
    logic [AW-1:0] req_addr;
    logic [31:0]   pattern;
    logic          in_req;
    logic          last;
    logic          tmo;

    // Word address and pattern for the current index; the address wraps mod 2^AW.
    always_comb begin
        addr_sum = 48'(BASE_ADDR) + {30'd0, idx, 2'b00};
        req_addr = addr_sum[AW-1:0];
        pattern  = {16'hA5A5 ^ idx, idx};
        in_req   = (state == S_WR_REQ) || (state == S_RD_REQ);
        last     = (idx == LAST_IDX);
        // The ack has priority over the timeout when both hit the same edge.
        tmo      = in_req && !wb_ack_i && (tcnt == TMO_MAX);
    end

    // Bus outputs are decoded from the state, so a reset drops cyc/stb at once.
    always_comb begin
        wb_cyc_o  = in_req;
        wb_stb_o  = in_req;
        wb_we_o   = (state == S_WR_REQ);
        wb_sel_o  = in_req ? 4'hF : 4'h0;
        wb_addr_o = in_req ? req_addr : '0;
        wb_dat_o  = in_req ? pattern : 32'h0;
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:      if (start) nxt = S_WAIT_INIT;
            S_WAIT_INIT: if (sdram_init_done) nxt = S_WR_REQ;
            S_WR_REQ:    if (wb_ack_i) nxt = S_WR_GAP;
                         else if (tmo) nxt = S_DONE;
            S_WR_GAP:    nxt = last ? S_RD_REQ : S_WR_REQ;
            S_RD_REQ:    if (wb_ack_i) nxt = S_RD_GAP;
                         else if (tmo) nxt = S_DONE;
            S_RD_GAP:    nxt = last ? S_DONE : S_RD_REQ;
            S_DONE:      if (start) nxt = S_WAIT_INIT;
            default:     nxt = S_IDLE;
        endcase
    end

    // Word index and per-transfer wait counter; the counter is zero on REQ entry.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx  <= '0;
            tcnt <= '0;
        end else begin
            case (state)
                S_WR_REQ, S_RD_REQ: if (!wb_ack_i) tcnt <= tcnt + 16'd1;
                S_WR_GAP: begin
                    tcnt <= '0;
                    idx  <= last ? 16'd0 : idx + 16'd1;
                end
                S_RD_GAP: begin
                    tcnt <= '0;
                    if (!last) idx <= idx + 16'd1;
                end
                default: begin
                    tcnt <= '0;
                    idx  <= '0;
                end
            endcase
        end
    end

    // Test status: clear on start, compare on read ack, latch the verdict on DONE entry.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            if (((state == S_IDLE) || (state == S_DONE)) && start) begin
                busy      <= 1'b1;
                done      <= 1'b0;
                pass      <= 1'b0;
                timeout   <= 1'b0;
                err_count <= '0;
                fail_addr <= '0;
            end
            if ((state == S_RD_REQ) && wb_ack_i && (wb_dat_i != pattern)) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'h0)    fail_addr <= req_addr;
            end
            if (tmo) timeout <= 1'b1;
            if ((nxt == S_DONE) && (state != S_DONE)) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_count == 16'h0) && !tmo;
            end
        end
    end

endmodule

// File: tb/tb_sdr_wb_bist_master.sv
// Bench for sdr_wb_bist_master: a small memory slave with configurable ack delay
// and read corruption, plus a scoreboard of expected bus transfers.
module tb_sdr_wb_bist_master;

    localparam int AW = 26;
    localparam int NW = 4;
    localparam int BASE = 32'h100;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          init_done;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [31:0]   dat_o, dat_i;
    logic          ack;
    logic          busy, done, pass, tmo_flag;
    logic [15:0]   err_count;
    logic [AW-1:0] fail_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration.
    int ack_en      = 1;
    int ack_delay   = 0;
    int corrupt_idx = -1;
    int all_bad     = 0;
    int wcnt        = 0;
    logic [31:0] mem [16];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } sb_t;
    sb_t sbq[$];

    sdr_wb_bist_master #(.AW(AW), .NUM_WORDS(NW), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .sdram_init_done(init_done),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
        .wb_addr_o(addr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_ack_i(ack),
        .busy(busy), .done(done), .pass(pass), .timeout(tmo_flag),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    assign ack   = (ack_en != 0) && stb && (wcnt >= ack_delay);
    assign dat_i = ((all_bad != 0) || (corrupt_idx == int'(addr[5:2]))) ? 32'h0 : mem[addr[5:2]];

    // Wait-state counter for the slave.
    always @(posedge clk) wcnt <= (stb && !ack) ? wcnt + 1 : 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [15:0] v;
        v = i[15:0];
        return {16'hA5A5 ^ v, v};
    endfunction

    // Expected transfers for one full run: NW writes then NW reads.
    task automatic push_run();
        for (int i = 0; i < NW; i++) sbq.push_back('{1'b1, AW'(BASE + 4 * i), pat(i)});
        for (int i = 0; i < NW; i++) sbq.push_back('{1'b0, AW'(BASE + 4 * i), 32'h0});
    endtask

    // Scoreboard monitor: every acked cycle is one completed transfer.
    always @(negedge clk) begin
        if (!rst && cyc && stb && ack) begin
            if (we) mem[addr[5:2]] <= dat_o;
            if (sbq.size() == 0) chk("sb_extra", 1, 0);
            else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_we", we, e.we);
                chk("sb_addr", addr, e.addr);
                chk("sb_sel", sel, 4'hF);
                if (e.we) chk("sb_data", dat_o, e.data);
            end
        end
    end

    // Pulse start, optionally hold init low, then wait (bounded) for done.
    task automatic run(input int hold, output int ncyc, output int first, output int reqc);
        @(negedge clk);
        start = 1'b1;
        if (hold > 0) init_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ncyc = 1; first = -1; reqc = 0;
        while (!done && ncyc < 2000) begin
            if (ncyc == 1 + hold) init_done = 1'b1;
            if (cyc) begin
                reqc++;
                if (first < 0) first = ncyc;
            end
            @(negedge clk);
            ncyc++;
        end
        if (!done) chk("done_wait_expired", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int nc, fc, rc;
        rst = 1'b1; start = 1'b0; init_done = 1'b1;
        #12;
        chk("rst_bus", {cyc, stb, we, sel}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_stat", {busy, done, pass, tmo_flag}, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fail", fail_addr, 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start", {cyc, busy}, 0);

        // Zero-wait slave.
        push_run();
        run(0, nc, fc, rc);
        chk("ideal_cycles", nc, 18);
        chk("ideal_first_req", fc, 2);
        chk("ideal_pass", pass, 1);
        chk("ideal_err", err_count, 0);
        chk("ideal_fail_addr", fail_addr, 0);
        chk("ideal_flags", {busy, tmo_flag, cyc}, 0);
        chk("ideal_sb_left", sbq.size(), 0);

        // Corrupt read of idx 2.
        corrupt_idx = 2;
        push_run();
        run(0, nc, fc, rc);
        chk("corrupt_err", err_count, 1);
        chk("corrupt_fail_addr", fail_addr, 26'h108);
        chk("corrupt_pass", pass, 0);
        chk("corrupt_done", done, 1);
        chk("corrupt_sb_left", sbq.size(), 0);
        corrupt_idx = -1;

        // Every read mismatches: first address is kept.
        all_bad = 1;
        push_run();
        run(0, nc, fc, rc);
        chk("allbad_err", err_count, 4);
        chk("allbad_fail_addr", fail_addr, 26'h100);
        chk("allbad_pass", pass, 0);
        all_bad = 0;

        // Slave never acks.
        ack_en = 0;
        run(0, nc, fc, rc);
        chk("tmo_req_cycles", rc, TMO);
        chk("tmo_cycles", nc, 12);
        chk("tmo_flag", tmo_flag, 1);
        chk("tmo_pass", pass, 0);
        chk("tmo_done", done, 1);
        chk("tmo_bus_idle", {cyc, stb, busy}, 0);
        ack_en = 1;

        // Ack on the last allowed cycle still succeeds.
        ack_delay = TMO - 1;
        push_run();
        run(0, nc, fc, rc);
        chk("edge_cycles", nc, 2 + 2 * NW * (TMO + 1));
        chk("edge_tmo_flag", tmo_flag, 0);
        chk("edge_pass", pass, 1);
        chk("edge_sb_left", sbq.size(), 0);
        ack_delay = 0;

        // Init held low for 50 cycles.
        push_run();
        run(50, nc, fc, rc);
        chk("init_first_req", fc, 52);
        chk("init_cycles", nc, 68);
        chk("init_pass", pass, 1);

        // Saturation: push err_count near the top during writes.
        all_bad = 1;
        push_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        force dut.err_count = 16'hFFFE;
        @(negedge clk);
        release dut.err_count;
        nc = 0;
        while (!done && nc < 2000) begin @(negedge clk); nc++; end
        chk("sat_done", done, 1);
        chk("sat_err", err_count, 16'hFFFF);
        chk("sat_fail_addr", fail_addr, 0);
        chk("sat_pass", pass, 0);
        all_bad = 0;

        // Reset in the middle of the read phase.
        push_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nc = 0;
        while (!(cyc && !we) && nc < 200) begin @(negedge clk); nc++; end
        chk("midrd_reached", cyc && !we, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrd_rst_bus", {cyc, stb, we, sel}, 0);
        chk("midrd_rst_addr_dat", {addr, dat_o}, 0);
        chk("midrd_rst_stat", {busy, done, pass, tmo_flag, err_count}, 0);
        sbq.delete();
        @(negedge clk); @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {cyc, busy, done}, 0);

        // Recovery run.
        push_run();
        run(0, nc, fc, rc);
        chk("recover_cycles", nc, 18);
        chk("recover_pass", pass, 1);
        chk("recover_sb_left", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
